// File: rtl/dcache_controller.sv
// dcache_controller: FSM sequencing hits, misses, line writebacks, line fills and clflush
// for a direct-mapped dcache datapath over a one-word-per-beat L2 handshake.
package dcache_pkg;
  typedef enum logic [1:0] {LOAD, STORE, CLFLUSH} memory_operation_e;
endpackage

module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINE_SIZE = 32,
  parameter int XLEN = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_req_valid,
  input  memory_operation_e    pipe_req_type,
  output logic                 pipe_req_fulfilled,
  input  logic                 hit,
  input  logic                 miss,
  input  logic                 valid_dirty_bit,
  input  logic                 clflush_requested,
  input  logic                 counter_done,
  output logic                 flush_mode,
  output logic                 load_mode,
  output logic                 clear_selected_dirty_bit,
  output logic                 clear_selected_valid_bit,
  output logic                 finish_new_line_install,
  output logic                 set_new_l2_block_address,
  output logic                 use_dirty_tag_for_l2_block_address,
  output logic                 reset_counter,
  output logic                 decrement_counter,
  output logic                 l2_req_valid,
  output memory_operation_e    l2_req_type,
  input  logic                 l2_req_fulfilled,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] writeback_count
);
  localparam int WORDS_PER_LINE = LINE_SIZE / (XLEN / 8);
  localparam int BW = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, INVALIDATE} state_e;

  state_e state, next;
  logic flush, hit_inc, miss_inc, wb_inc, clean_hit;
  logic [BW-1:0] beats;

  // A hit only counts when it is unambiguous; anything else falls through to the miss path.
  assign clean_hit = hit && !miss && (pipe_req_type == LOAD || pipe_req_type == STORE);

  always_comb begin
    next = state;
    {pipe_req_fulfilled, flush_mode, load_mode, clear_selected_dirty_bit, clear_selected_valid_bit,
     finish_new_line_install, set_new_l2_block_address, use_dirty_tag_for_l2_block_address,
     reset_counter, decrement_counter, l2_req_valid, hit_inc, miss_inc, wb_inc} = '0;
    l2_req_type = LOAD;
    if (reset)
      case (state)
        IDLE: if (pipe_req_valid) begin
          if (clflush_requested) begin
            set_new_l2_block_address = valid_dirty_bit;
            use_dirty_tag_for_l2_block_address = valid_dirty_bit;
            reset_counter = valid_dirty_bit;
            next = valid_dirty_bit ? WRITEBACK : INVALIDATE;
          end else if (clean_hit) begin
            pipe_req_fulfilled = 1'b1;
            hit_inc = 1'b1;
          end else if (hit || miss) begin
            miss_inc = 1'b1;
            set_new_l2_block_address = 1'b1;
            use_dirty_tag_for_l2_block_address = valid_dirty_bit;
            reset_counter = 1'b1;
            next = valid_dirty_bit ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          flush_mode = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type = STORE;
          decrement_counter = l2_req_fulfilled && !counter_done;
          if (l2_req_fulfilled && counter_done) begin
            clear_selected_dirty_bit = 1'b1;
            wb_inc = 1'b1;
            set_new_l2_block_address = !flush;
            reset_counter = !flush;
            next = flush ? INVALIDATE : FILL;
          end
        end
        FILL: begin
          load_mode = 1'b1;
          l2_req_valid = 1'b1;
          decrement_counter = l2_req_fulfilled && !counter_done;
          if (l2_req_fulfilled && counter_done) begin
            finish_new_line_install = 1'b1;
            clear_selected_dirty_bit = 1'b1;
            next = IDLE;
          end
        end
        INVALIDATE: begin
          clear_selected_valid_bit = 1'b1;
          pipe_req_fulfilled = 1'b1;
          next = IDLE;
        end
        default: next = IDLE;
      endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      flush <= 1'b0;
      beats <= '0;
      hit_count <= '0;
      miss_count <= '0;
      writeback_count <= '0;
    end else begin
      state <= next;
      if (state == IDLE) flush <= clflush_requested;
      if (reset_counter) beats <= '0;
      else if (l2_req_valid && l2_req_fulfilled) beats <= beats + 1'b1;
      if (hit_inc && !(&hit_count)) hit_count <= hit_count + 1'b1;
      if (miss_inc && !(&miss_count)) miss_count <= miss_count + 1'b1;
      if (wb_inc && !(&writeback_count)) writeback_count <= writeback_count + 1'b1;
    end
  end

  // Simulation-only sanity checks on datapath status and line length.
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && pipe_req_valid)
      assert (!(hit && miss) && pipe_req_type inside {LOAD, STORE, CLFLUSH});
    if (reset && l2_req_valid && l2_req_fulfilled && counter_done)
      assert (beats == BW'(WORDS_PER_LINE - 1));
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: random requests against a small direct-mapped cache model; expected
// transaction outcomes are queued at issue and checked by an independent monitor.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int K_HIT = 0, K_FIN = 1, K_INV = 2;

  logic clk = 1'b0, reset = 1'b0;
  logic pipe_req_valid = 1'b0, pipe_req_fulfilled;
  memory_operation_e pipe_req_type = LOAD, l2_req_type;
  logic hit, miss, valid_dirty_bit, clflush_requested, counter_done;
  logic flush_mode, load_mode, clear_selected_dirty_bit, clear_selected_valid_bit;
  logic finish_new_line_install, set_new_l2_block_address, use_dirty_tag_for_l2_block_address;
  logic reset_counter, decrement_counter, l2_req_valid, l2_req_fulfilled = 1'b0;
  logic [31:0] hit_count, miss_count, writeback_count;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk(clk), .reset(reset), .pipe_req_valid(pipe_req_valid), .pipe_req_type(pipe_req_type),
    .pipe_req_fulfilled(pipe_req_fulfilled), .hit(hit), .miss(miss),
    .valid_dirty_bit(valid_dirty_bit), .clflush_requested(clflush_requested),
    .counter_done(counter_done), .flush_mode(flush_mode), .load_mode(load_mode),
    .clear_selected_dirty_bit(clear_selected_dirty_bit),
    .clear_selected_valid_bit(clear_selected_valid_bit),
    .finish_new_line_install(finish_new_line_install),
    .set_new_l2_block_address(set_new_l2_block_address),
    .use_dirty_tag_for_l2_block_address(use_dirty_tag_for_l2_block_address),
    .reset_counter(reset_counter), .decrement_counter(decrement_counter),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type), .l2_req_fulfilled(l2_req_fulfilled),
    .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
  );

  // Datapath model: 4-set direct-mapped tag store plus the beat counter.
  logic v [4] = '{default: 1'b0};
  logic d [4] = '{default: 1'b0};
  logic [3:0] tg [4] = '{default: 4'd0};
  logic [1:0] req_idx = 2'd0;
  logic [3:0] req_tag = 4'd0;
  logic [2:0] cnt = 3'd0;
  logic m_now, cf_now;

  always_comb begin
    m_now = v[req_idx] && tg[req_idx] == req_tag;
    cf_now = pipe_req_type == CLFLUSH;
    clflush_requested = cf_now;
    hit = !cf_now && m_now;
    miss = !cf_now && !m_now;
    valid_dirty_bit = v[req_idx] && d[req_idx] && (!cf_now || m_now);
    counter_done = cnt == 3'd0;
  end

  always @(posedge clk) begin
    if (reset_counter) cnt <= 3'd7;
    else if (decrement_counter) cnt <= cnt - 3'd1;
    if (clear_selected_dirty_bit) d[req_idx] <= 1'b0;
    if (clear_selected_valid_bit) v[req_idx] <= 1'b0;
    if (finish_new_line_install) begin
      v[req_idx] <= 1'b1;
      tg[req_idx] <= req_tag;
      d[req_idx] <= 1'b0;
    end
    if (pipe_req_fulfilled && pipe_req_type == STORE) d[req_idx] <= 1'b1;
  end

  int l2_rate = 70;
  initial forever begin
    @(posedge clk);
    #1 l2_req_fulfilled = $urandom_range(0, 99) < l2_rate;
  end

  typedef struct {
    int kind, wb, fl, dec, sets, dt;
    logic [31:0] hc, mc, wc;
  } exp_t;

  exp_t sb [$];
  logic [31:0] hits = 0, misses = 0, wbs = 0;
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int k, wb, fl, dec, sets, dt);
    mk.kind = k; mk.wb = wb; mk.fl = fl; mk.dec = dec; mk.sets = sets; mk.dt = dt;
    mk.hc = hits; mk.mc = misses; mk.wc = wbs;
  endfunction

  // Monitor: accumulate per-transaction activity, compare on each completion event.
  int a_wb = 0, a_fl = 0, a_dec = 0, a_sets = 0, a_dt = 0, kind;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      a_wb = 0; a_fl = 0; a_dec = 0; a_sets = 0; a_dt = 0;
    end else begin
      if (l2_req_valid)
        check("l2_mode", {flush_mode, load_mode}, l2_req_type == STORE ? 2'b10 : 2'b01);
      if (l2_req_valid && l2_req_fulfilled) begin
        if (l2_req_type == STORE) a_wb++;
        else a_fl++;
      end
      if (decrement_counter) a_dec++;
      if (set_new_l2_block_address) begin
        a_sets++;
        if (use_dirty_tag_for_l2_block_address) a_dt++;
      end
      if (pipe_req_fulfilled || finish_new_line_install) begin
        kind = finish_new_line_install ? K_FIN : clear_selected_valid_bit ? K_INV : K_HIT;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
          e = sb.pop_front();
          check("kind", kind, e.kind);
          check("wb_beats", a_wb, e.wb);
          check("fill_beats", a_fl, e.fl);
          check("decrements", a_dec, e.dec);
          check("addr_sets", a_sets, e.sets);
          check("dirty_tag_sets", a_dt, e.dt);
          check("hit_count", hit_count, e.hc);
          check("miss_count", miss_count, e.mc);
          check("writeback_count", writeback_count, e.wc);
        end
        a_wb = 0; a_fl = 0; a_dec = 0; a_sets = 0; a_dt = 0;
      end
    end
  end

  task automatic do_reset(input bit req_on);
    @(posedge clk);
    #1 reset = 1'b0;
    pipe_req_valid = req_on;
    sb.delete();
    hits = 0; misses = 0; wbs = 0;
    @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {pipe_req_fulfilled, flush_mode, load_mode, clear_selected_dirty_bit,
      clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address,
      use_dirty_tag_for_l2_block_address, reset_counter, decrement_counter, l2_req_valid}, 0);
    check("reset_l2_type", l2_req_type, LOAD);
    check("reset_hit_count", hit_count, 0);
    check("reset_miss_count", miss_count, 0);
    check("reset_wb_count", writeback_count, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    pipe_req_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] idx, input logic [3:0] t, input memory_operation_e op,
                       input bit drop);
    bit m, dty, done, dr;
    m = v[idx] && tg[idx] == t;
    dty = v[idx] && d[idx];
    dr = drop && op != CLFLUSH && !m;
    if (op == CLFLUSH) begin
      if (m && dty) wbs++;
      sb.push_back(mk(K_INV, m && dty ? 8 : 0, 0, m && dty ? 7 : 0, m && dty, m && dty));
    end else if (m) begin
      sb.push_back(mk(K_HIT, 0, 0, 0, 0, 0));
      hits++;
    end else begin
      misses++;
      if (dty) wbs++;
      sb.push_back(mk(K_FIN, dty ? 8 : 0, 8, dty ? 14 : 7, dty ? 2 : 1, dty));
      if (!dr) begin
        sb.push_back(mk(K_HIT, 0, 0, 0, 0, 0));
        hits++;
      end
    end
    @(posedge clk);
    #1 req_idx = idx;
    req_tag = t;
    pipe_req_type = op;
    pipe_req_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (dr && load_mode) pipe_req_valid = 1'b0;
      done = dr ? finish_new_line_install : pipe_req_fulfilled;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no completion expected completion for op %0d", op);
      do_reset(1'b0);
    end else begin
      @(posedge clk);
      #1 pipe_req_valid = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int r;
    memory_operation_e op;
    do_reset(1'b1);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      op = r < 2 ? CLFLUSH : r < 6 ? STORE : LOAD;
      if (i % 20 == 0) l2_rate = $urandom_range(0, 1) ? 100 : 55;
      issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), op, $urandom_range(0, 14) == 0);
    end
    // Reset arriving on the fourth fill beat must abandon the fill silently.
    l2_rate = 100;
    @(posedge clk);
    #1 req_idx = 2'd1;
    req_tag = 4'd9;
    pipe_req_type = LOAD;
    pipe_req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = load_mode && cnt == 3'd4;
    end
    check("reached_fill_beat4", ok, 1'b1);
    do_reset(1'b1);
    @(negedge clk);
    check("idle_after_reset", {l2_req_valid, load_mode, flush_mode}, 0);
    l2_rate = 70;
    for (int i = 0; i < 30; i++)
      issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 1) ? STORE : LOAD, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("final_hit_count", hit_count, hits);
    check("final_miss_count", miss_count, misses);
    check("final_wb_count", writeback_count, wbs);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Moore/Mealy FSM that sequences the direct-mapped dcache datapath.
- Decodes hit, miss, dirty and clflush status from the datapath and drives its mode, metadata and counter strobes.
- Runs line writebacks and line fills over a one-word-per-beat L2 handshake.
- Sits between the pipeline request port and the L2 port; owns no data storage.

Parameters:
- LINE_SIZE, 32: bytes per cache line.
- XLEN, 32: word width in bits. WORDS_PER_LINE = LINE_SIZE/(XLEN/8), so 8 beats per line at the defaults.
- CNT_WIDTH, 32: width of each saturating performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pipe_req_valid  in  1  pipeline request present. Request fields are held stable by the pipeline until pipe_req_fulfilled.
- pipe_req_type  in  memory_operation_e  LOAD, STORE or CLFLUSH.
- pipe_req_fulfilled  out  1  single-cycle completion strobe to the pipeline.
- hit, miss, valid_dirty_bit, clflush_requested, counter_done  in  1 each  datapath status.
- flush_mode, load_mode  out  1 each  datapath read/write steering.
- clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install  out  1 each  metadata strobes.
- set_new_l2_block_address, use_dirty_tag_for_l2_block_address  out  1 each  L2 address latch control.
- reset_counter, decrement_counter  out  1 each  datapath beat counter control.
- l2_req_valid  out  1  L2 beat request.
- l2_req_type  out  memory_operation_e  LOAD (fill) or STORE (writeback).
- l2_req_fulfilled  in  1  L2 beat accepted or returned this cycle.
- hit_count, miss_count, writeback_count  out  CNT_WIDTH each  saturating event counters.

Behaviour:
- States: IDLE, WRITEBACK, FILL, INVALIDATE.
- Reset (reset==0 at a clock edge): state goes to IDLE and all counters clear to 0. This applies mid-writeback or mid-fill with no completion strobes. Every strobe output is 0 while reset is low, and l2_req_type is LOAD.
- All strobe outputs default to 0 in every state unless listed below.

IDLE, with pipe_req_valid=1:
- clflush_requested=1 and valid_dirty_bit=1: assert set_new_l2_block_address, use_dirty_tag_for_l2_block_address and reset_counter; go to WRITEBACK.
- clflush_requested=1 and valid_dirty_bit=0: go to INVALIDATE.
- hit=1 (LOAD or STORE): pipe_req_fulfilled=1 in the same cycle, no state change. The datapath commits the store on that edge. hit_count increments.
- miss=1 and valid_dirty_bit=1: assert set_new_l2_block_address, use_dirty_tag_for_l2_block_address and reset_counter; go to WRITEBACK. miss_count increments.
- miss=1 and valid_dirty_bit=0: assert set_new_l2_block_address (use_dirty_tag=0) and reset_counter; go to FILL. miss_count increments.

WRITEBACK:
- flush_mode=1, l2_req_valid=1, l2_req_type=STORE.
- On l2_req_fulfilled with counter_done=0: assert decrement_counter.
- On l2_req_fulfilled with counter_done=1 (last beat): assert clear_selected_dirty_bit and increment writeback_count.
  - If the request is CLFLUSH, go to INVALIDATE.
  - Otherwise assert set_new_l2_block_address (use_dirty_tag=0) and reset_counter, then go to FILL.

FILL:
- load_mode=1, l2_req_valid=1, l2_req_type=LOAD.
- On l2_req_fulfilled with counter_done=0: assert decrement_counter.
- On l2_req_fulfilled with counter_done=1: assert finish_new_line_install and clear_selected_dirty_bit, then go to IDLE. The retried access then hits one cycle later, so a miss is never fulfilled from FILL directly.

INVALIDATE:
- Assert clear_selected_valid_bit and pipe_req_fulfilled for one cycle, then go to IDLE.

Edge cases:
- Line transfer is exactly WORDS_PER_LINE fulfilled beats. The counter starts at all-ones and counts down; counter_done marks the final beat.
- A beat without l2_req_fulfilled holds state and all outputs, so L2 may stall indefinitely.
- If pipe_req_valid drops during WRITEBACK or FILL, the transfer still completes and no pipe_req_fulfilled is issued.
- If hit and miss are both 1, or pipe_req_type is unknown while valid, that is an assertion failure in simulation. The RTL treats it as a miss.
- Counters saturate at all-ones and never wrap.

Test Plan:
1. Load hit: preloaded line, LOAD with hit=1 → pipe_req_fulfilled=1 in the same cycle, state stays IDLE, hit_count=1.
2. Clean miss: miss=1, valid_dirty_bit=0, L2 fulfils each cycle → set_new_l2_block_address and reset_counter in cycle 0, then 8 FILL beats with 7 decrement_counter pulses, finish_new_line_install on beat 8, IDLE on the next cycle, miss_count=1.
3. Dirty miss: valid_dirty_bit=1 → 8 STORE beats with flush_mode=1 and use_dirty_tag=1 at entry, clear_selected_dirty_bit on beat 8, then 8 LOAD beats, writeback_count=1.
4. L2 stall: during FILL, l2_req_fulfilled low for 5 cycles on beat 3 → no decrement_counter, outputs stable, fill completes after 8 total fulfilled beats.
5. CLFLUSH: dirty line → 8 writeback beats, then clear_selected_valid_bit and pipe_req_fulfilled together. Clean line → both asserted 1 cycle after the request.
6. Reset mid-FILL: reset=0 on beat 4 → next cycle IDLE, all strobes 0, all counters 0, no finish_new_line_install.
